fft2_pair_feeder: RTL and testbench

Streaming front end for the radix-2 butterfly stage. Accepts a serial stream of complex samples, one per handshake, and buffers the first half of each N-sample frame. As each second-half sample arrives, it presents the pair (x[n], x[n+N/2]) on registered outputs that drive the butterfly's `a_re/a_img/b_re/b_img` inputs. It provides the decimation-in-frequency pairing that the butterfly itself does not perform.

---
 rtl/fft2_pair_feeder.sv | 138 +++++++++++++
 tb/tb_fft2_pair_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fft2_pair_feeder.sv
// fft2_pair_feeder: buffers the first half of each N-sample frame and emits
// (x[n], x[n+N/2]) pairs on registered outputs for a radix-2 DIF butterfly.
// Build macro FFT2_FEEDER_LAST_CHECK_EN adds the s_last input and the
// frame_err output. Without it, framing comes purely from the sample counter.
module fft2_pair_feeder #(
  parameter  int unsigned N    = 8,
  parameter  int unsigned DW   = 32,
  localparam int unsigned HALF = N / 2,
  localparam int unsigned IW   = (HALF > 1) ? $clog2(HALF) : 1,
  localparam int unsigned KW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FFT2_FEEDER_LAST_CHECK_EN
  input  logic          s_last,
  output logic          frame_err,
`endif
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_img,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] a_re,
  output logic [DW-1:0] a_img,
  output logic [DW-1:0] b_re,
  output logic [DW-1:0] b_img,
  output logic          p_valid,
  input  logic          p_ready,
  output logic [IW-1:0] p_idx,
  output logic          p_last
);

  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [DW-1:0] r_a_re, r_a_img, r_b_re, r_b_img;
  logic          r_p_valid;
  logic [IW-1:0] r_p_idx;
  logic          r_p_last;

  // First-half storage; written only in FILL, read only in PAIR
  logic [DW-1:0] r_buf_re  [HALF];
  logic [DW-1:0] r_buf_img [HALF];

  logic          w_accept;
  logic          w_load;
  logic          w_k_end;
  logic          w_half_end;
  logic          w_early;
  logic          w_frame_end;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;

  // Output register may refill whenever it is empty or being drained
  assign s_ready     = (r_state == FILL) || !r_p_valid || p_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_load      = w_accept && (r_state == PAIR);
  assign w_k_end     = (r_k == KW'(N - 1));
  assign w_half_end  = (r_k == KW'(HALF - 1));
  assign w_widx      = IW'(r_k);
  assign w_ridx      = IW'(r_k - KW'(HALF));
  assign w_frame_end = w_k_end || w_early;

`ifdef FFT2_FEEDER_LAST_CHECK_EN
  logic r_frame_err;

  // Early s_last restarts the frame after the sample is handled normally
  assign w_early   = s_last && !w_k_end;
  assign frame_err = r_frame_err;

  // One-cycle pulse when s_last disagrees with the counter's frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && (s_last != w_k_end);
    end
  end
`else
  assign w_early = 1'b0;
`endif

  // Buffer write during FILL; contents need no reset
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == FILL)) begin
      r_buf_re[w_widx]  <= s_re;
      r_buf_img[w_widx] <= s_img;
    end
  end

  // Frame FSM, sample counter and registered pair outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FILL;
      r_k       <= '0;
      r_a_re    <= '0;
      r_a_img   <= '0;
      r_b_re    <= '0;
      r_b_img   <= '0;
      r_p_valid <= 1'b0;
      r_p_idx   <= '0;
      r_p_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_re    <= r_buf_re[w_ridx];
        r_a_img   <= r_buf_img[w_ridx];
        r_b_re    <= s_re;
        r_b_img   <= s_img;
        r_p_idx   <= w_ridx;
        r_p_last  <= w_k_end;
        r_p_valid <= 1'b1;
      end else if (p_ready) begin
        r_p_valid <= 1'b0;
      end

      if (w_accept) begin
        if (w_frame_end) begin
          r_k     <= '0;
          r_state <= FILL;
        end else begin
          r_k <= r_k + KW'(1);
          if ((r_state == FILL) && w_half_end) begin
            r_state <= PAIR;
          end
        end
      end
    end
  end

  assign a_re    = r_a_re;
  assign a_img   = r_a_img;
  assign b_re    = r_b_re;
  assign b_img   = r_b_img;
  assign p_valid = r_p_valid;
  assign p_idx   = r_p_idx;
  assign p_last  = r_p_last;

endmodule

// File: tb/tb_fft2_pair_feeder.sv
// Directed, table-driven bench for fft2_pair_feeder with N=8, DW=32.
// Build macro FFT2_FEEDER_LAST_CHECK_EN enables the s_last / frame_err cases.
module tb_fft2_pair_feeder;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_re;
  logic [DW-1:0] s_img;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] a_re;
  logic [DW-1:0] a_img;
  logic [DW-1:0] b_re;
  logic [DW-1:0] b_img;
  logic          p_valid;
  logic          p_ready;
  logic [1:0]    p_idx;
  logic          p_last;
  logic          s_last;
  logic          frame_err;

  fft2_pair_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FFT2_FEEDER_LAST_CHECK_EN
    .s_last    (s_last),
    .frame_err (frame_err),
`endif
    .s_re      (s_re),
    .s_img     (s_img),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .a_re      (a_re),
    .a_img     (a_img),
    .b_re      (b_re),
    .b_img     (b_img),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_idx     (p_idx),
    .p_last    (p_last)
  );

`ifndef FFT2_FEEDER_LAST_CHECK_EN
  assign frame_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] re;
    logic        last;
    logic        pready;
    logic        exp_sready;
    logic        exp_pvalid;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [1:0]  exp_idx;
    logic        exp_plast;
    logic        exp_ferr;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [31:0] re, input logic lst,
                              input logic pr, input logic esr, input logic epv,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [1:0] eidx, input logic elast, input logic eferr);
    vec_t t;
    t.valid = v; t.re = re; t.last = lst; t.pready = pr;
    t.exp_sready = esr; t.exp_pvalid = epv; t.exp_a = ea; t.exp_b = eb;
    t.exp_idx = eidx; t.exp_plast = elast; t.exp_ferr = eferr;
    tbl.push_back(t);
  endfunction

  // Streamed frame at full rate starting at x[0]=base.
  // mode 0: s_last on each 8th sample; 1: never; 2: s_last on final sample given.
  function automatic void add_frame(input int base, input int n, input int mode);
    for (int s = 0; s < n; s++) begin
      int f = s % 8;
      logic lst = (mode == 0) ? (f == 7) : ((mode == 2) && (s == n - 1));
      logic ferr = (lst != (f == 7));
      if (f >= 4)
        add(1'b1, 32'(base + s), lst, 1'b1, 1'b1, 1'b1, 32'(base + s - 4),
            32'(base + s), 2'(f - 4), f == 7, ferr);
      else
        add(1'b1, 32'(base + s), lst, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, ferr);
    end
  endfunction

  function automatic void add_idle();
    add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  // Apply each row for one clock: s_ready checked before the edge, pair after
  task automatic run(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      s_valid = tbl[i].valid;
      s_re    = tbl[i].re;
      s_img   = '0;
      s_last  = tbl[i].last;
      p_ready = tbl[i].pready;
      #1;
      chk($sformatf("%s[%0d].s_ready", tag, i), 32'(s_ready), 32'(tbl[i].exp_sready));
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].p_valid", tag, i), 32'(p_valid), 32'(tbl[i].exp_pvalid));
`ifdef FFT2_FEEDER_LAST_CHECK_EN
      chk($sformatf("%s[%0d].frame_err", tag, i), 32'(frame_err), 32'(tbl[i].exp_ferr));
`endif
      if (tbl[i].exp_pvalid) begin
        chk($sformatf("%s[%0d].a_re", tag, i), a_re, tbl[i].exp_a);
        chk($sformatf("%s[%0d].b_re", tag, i), b_re, tbl[i].exp_b);
        chk($sformatf("%s[%0d].img", tag, i), a_img | b_img, 32'd0);
        chk($sformatf("%s[%0d].p_idx", tag, i), 32'(p_idx), 32'(tbl[i].exp_idx));
        chk($sformatf("%s[%0d].p_last", tag, i), 32'(p_last), 32'(tbl[i].exp_plast));
      end
    end
    s_valid = 1'b0;
    tbl.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    p_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_re = '0; s_img = '0; s_valid = 1'b0; s_last = 1'b0; p_ready = 1'b1;

    // Reset state
    do_reset();
    #1;
    chk("rst.p_valid", 32'(p_valid), 32'd0);
    chk("rst.p_last", 32'(p_last), 32'd0);
    chk("rst.p_idx", 32'(p_idx), 32'd0);
    chk("rst.data", a_re | a_img | b_re | b_img, 32'd0);
    chk("rst.s_ready", 32'(s_ready), 32'd1);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;

    // Basic frame 1..8
    add_frame(1, 8, 0);
    add_idle();
    run("basic");

    // Backpressure while (2,6) is held
    do_reset();
    add_frame(1, 6, 0);
    for (int i = 0; i < 3; i++)
      add(1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd6, 2'd1, 1'b0, 1'b0);
    add(1'b1, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 32'd7, 2'd2, 1'b0, 1'b0);
    add(1'b1, 32'd8, 1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 32'd8, 2'd3, 1'b1, 1'b0);
    add_idle();
    run("bp");

    // Two back-to-back frames 1..16
    do_reset();
    add_frame(1, 16, 0);
    add_idle();
    run("cont");

    // Reset after sample 6 drops the held pair immediately
    do_reset();
    add_frame(1, 6, 0);
    run("pre_rst");
    rst = 1'b1;
    #1;
    chk("midrst.p_valid", 32'(p_valid), 32'd0);
    chk("midrst.p_idx", 32'(p_idx), 32'd0);
    chk("midrst.s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_frame(10, 8, 0);
    add_idle();
    run("post_rst");

`ifdef FFT2_FEEDER_LAST_CHECK_EN
    // Early s_last on sample 6, then a clean frame, then a missing s_last
    do_reset();
    add_frame(1, 6, 2);
    add_frame(20, 8, 0);
    add_idle();
    add_frame(30, 8, 1);
    add_idle();
    run("last");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
